// File: rtl/acpo_buff_reader.sv
// acpo_buff_reader: streams a contiguous range of entries out of a banked data buffer
// (and optionally the matching address buffer) onto a valid/ready interface.
// Reads are issued only when the 2-entry output FIFO is guaranteed to have room one
// cycle later, so the stream never drops a word under backpressure.
// Optional feature macro: ACPO_RD_ADDR_EN (address buffer read path + address FIFO).
module acpo_buff_reader #(
    parameter int unsigned SRAM_DEPTH    = 1024,
    parameter int unsigned BAND_WIDTH    = 16,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 10,
    localparam int unsigned AW = $clog2(SRAM_DEPTH) + $clog2(BAND_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [AW-1:0]            base_i,
    input  logic [AW:0]              count_i,
    output logic                     enb_d_o,
    output logic                     enb_a_o,
    output logic [AW-1:0]            addrb_o,
    input  logic [DATA_WIDTH-1:0]    dob_d_i,
    input  logic [ADDRESS_WIDTH-1:0] dob_a_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DATA_WIDTH-1:0]    out_data_o,
    output logic [ADDRESS_WIDTH-1:0] out_addr_o,
    output logic                     out_last_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam logic [AW-1:0] PTR_MAX = AW'(SRAM_DEPTH * BAND_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [AW:0]     issued_q, issued_d;
    logic [AW:0]     beat_q, beat_d;
    logic            inflight_q, inflight_d;

    logic [DATA_WIDTH-1:0] data_q [2];
    logic [DATA_WIDTH-1:0] data_d [2];
    logic                  fifo_wr_q, fifo_wr_d;
    logic                  fifo_rd_q, fifo_rd_d;
    logic [1:0]            fifo_cnt_q, fifo_cnt_d;

`ifdef ACPO_RD_ADDR_EN
    logic [ADDRESS_WIDTH-1:0] addr_q [2];
    logic [ADDRESS_WIDTH-1:0] addr_d [2];
`else
    logic unused_dob_a;
    assign unused_dob_a = ^dob_a_i;
`endif

    logic       push;
    logic       pop;
    logic       issue;
    logic [2:0] level_after_pop;

    // Handshake, read issue decision and output drive.
    always_comb begin
        push            = inflight_q;
        out_valid_o     = (fifo_cnt_q != 2'd0);
        pop             = out_valid_o && out_ready_i;
        // Words buffered plus the one returning, minus the one leaving this cycle:
        // a new read is safe only if that leaves at least one free slot.
        level_after_pop = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue           = (state_q == StRead) && (level_after_pop < 3'd2) &&
                          (issued_q != count_q);
        enb_d_o         = issue;
`ifdef ACPO_RD_ADDR_EN
        enb_a_o         = issue;
        out_addr_o      = addr_q[fifo_rd_q];
`else
        enb_a_o         = 1'b0;
        out_addr_o      = '0;
`endif
        addrb_o         = ptr_q;
        out_data_o      = data_q[fifo_rd_q];
        out_last_o      = out_valid_o && ((beat_q + 1'b1) == count_q);
        busy_o          = (state_q != StIdle);
        done_o          = (state_q == StDone);
    end

    // Pass sequencing: pointer, issued-read and beat counters, state transitions.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        issued_d   = issued_q;
        beat_d     = beat_q;
        inflight_d = issue;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    count_d  = count_i;
                    ptr_d    = base_i;
                    issued_d = '0;
                    beat_d   = '0;
                    state_d  = (count_i == '0) ? StDone : StRead;
                end
            end
            StRead: begin
                if (issue) begin
                    ptr_d    = (ptr_q == PTR_MAX) ? '0 : ptr_q + 1'b1;
                    issued_d = issued_q + 1'b1;
                    if (issued_d == count_q) begin
                        state_d = StDrain;
                    end
                end
                if (pop) begin
                    beat_d = beat_q + 1'b1;
                end
            end
            StDrain: begin
                if (pop) begin
                    beat_d = beat_q + 1'b1;
                    if (out_last_o) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output FIFO: capture the word returning from the read issued last cycle.
    always_comb begin
        data_d     = data_q;
`ifdef ACPO_RD_ADDR_EN
        addr_d     = addr_q;
`endif
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            data_d[fifo_wr_q] = dob_d_i;
`ifdef ACPO_RD_ADDR_EN
            addr_d[fifo_wr_q] = dob_a_i;
`endif
            fifo_wr_d = ~fifo_wr_q;
        end
        if (pop) begin
            fifo_rd_d = ~fifo_rd_q;
        end
    end

    // State registers; reset discards everything buffered or in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            beat_q     <= '0;
            inflight_q <= 1'b0;
            data_q[0]  <= '0;
            data_q[1]  <= '0;
`ifdef ACPO_RD_ADDR_EN
            addr_q[0]  <= '0;
            addr_q[1]  <= '0;
`endif
            fifo_wr_q  <= 1'b0;
            fifo_rd_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            issued_q   <= issued_d;
            beat_q     <= beat_d;
            inflight_q <= inflight_d;
            data_q[0]  <= data_d[0];
            data_q[1]  <= data_d[1];
`ifdef ACPO_RD_ADDR_EN
            addr_q[0]  <= addr_d[0];
            addr_q[1]  <= addr_d[1];
`endif
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

endmodule

// File: tb/tb_acpo_buff_reader.sv
// Bench for acpo_buff_reader at default parameters. The buffers are modelled as
// one-cycle-latency memories with contents derived from the address; the expected
// stream of every pass is computed directly from base/count.
module tb_acpo_buff_reader;

    localparam int AW    = 14;
    localparam int TOTAL = 16384;

    logic            clk;
    logic            rst;
    logic            start_i;
    logic [AW-1:0]   base_i;
    logic [AW:0]     count_i;
    logic            enb_d_o;
    logic            enb_a_o;
    logic [AW-1:0]   addrb_o;
    logic [7:0]      dob_d_i;
    logic [9:0]      dob_a_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [7:0]      out_data_o;
    logic [9:0]      out_addr_o;
    logic            out_last_o;
    logic            busy_o;
    logic            done_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    acpo_buff_reader dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .base_i      (base_i),
        .count_i     (count_i),
        .enb_d_o     (enb_d_o),
        .enb_a_o     (enb_a_o),
        .addrb_o     (addrb_o),
        .dob_d_i     (dob_d_i),
        .dob_a_i     (dob_a_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_addr_o  (out_addr_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] mem_data(input int a);
        return 8'((a * 29) ^ (a >> 6) ^ 90);
    endfunction

    function automatic logic [9:0] exp_oaddr(input int a);
`ifdef ACPO_RD_ADDR_EN
        return 10'(a + 100);
`else
        return 10'(a - a);
`endif
    endfunction

    // Buffer models: read data appears the cycle after the enable.
    always @(posedge clk) begin
        if (enb_d_o) dob_d_i <= mem_data(int'(addrb_o));
        if (enb_a_o) dob_a_i <= 10'(int'(addrb_o) + 100);
    end

    // Observations of the most recent pass.
    int         rd_addr_q[$];
    int         rd_cyc_q[$];
    logic [7:0] bd_q[$];
    logic [9:0] ba_q[$];
    bit         bl_q[$];
    int         beat_cyc_q[$];
    int         first_enb, first_valid, done_cyc, done_cnt, stall_err, max_ahead, ea_err;

    // Drives one pass and records what the DUT did; mode 0 ready=1, 1 toggle, 2 random.
    task automatic run_pass(input int base, input int cnt, input int mode, input int restart_cyc);
        int issued, beats;
        bit prev_v, prev_r;
        logic [7:0] prev_d;
        logic [9:0] prev_a;
        rd_addr_q.delete(); rd_cyc_q.delete(); bd_q.delete(); ba_q.delete();
        bl_q.delete(); beat_cyc_q.delete();
        first_enb = -1; first_valid = -1; done_cyc = -1; done_cnt = 0;
        stall_err = 0; max_ahead = 0; ea_err = 0;
        issued = 0; beats = 0; prev_v = 0; prev_r = 0; prev_d = '0; prev_a = '0;
        @(negedge clk);
        start_i = 1'b1; base_i = AW'(base); count_i = (AW+1)'(cnt); out_ready_i = 1'b1;
        for (int cyc = 1; cyc < 300; cyc++) begin
            @(negedge clk);
            start_i = (cyc == restart_cyc);
            if (start_i) begin
                base_i  = AW'($urandom);
                count_i = '0;
            end
            if (mode == 0) out_ready_i = 1'b1;
            else if (mode == 1) out_ready_i = ((cyc & 1) == 0);
            else out_ready_i = ($urandom_range(0, 2) != 0);
            #1;
`ifdef ACPO_RD_ADDR_EN
            if (enb_a_o !== enb_d_o) ea_err++;
`else
            if (enb_a_o !== 1'b0) ea_err++;
`endif
            if (enb_d_o) begin
                rd_addr_q.push_back(int'(addrb_o));
                rd_cyc_q.push_back(cyc);
                if (first_enb < 0) first_enb = cyc;
                issued++;
            end
            if (out_valid_o && first_valid < 0) first_valid = cyc;
            if (prev_v && !prev_r &&
                (!out_valid_o || out_data_o !== prev_d || out_addr_o !== prev_a)) stall_err++;
            if (out_valid_o && out_ready_i) begin
                bd_q.push_back(out_data_o);
                ba_q.push_back(out_addr_o);
                bl_q.push_back(out_last_o);
                beat_cyc_q.push_back(cyc);
                beats++;
            end
            if (done_o) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (issued - beats > max_ahead) max_ahead = issued - beats;
            prev_v = out_valid_o; prev_r = out_ready_i; prev_d = out_data_o; prev_a = out_addr_o;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        start_i = 1'b0;
        if (done_cyc < 0) $display("FAIL pass_timeout: base=%0d count=%0d no done_o", base, cnt);
    endtask

    task automatic test_reset();
        #2;
        total_cnt++;
        if ({out_valid_o, out_last_o, enb_d_o, enb_a_o, busy_o, done_o} !== 6'b0) begin
            $display("FAIL reset_ctrl: got %b want 000000",
                     {out_valid_o, out_last_o, enb_d_o, enb_a_o, busy_o, done_o});
        end else pass_cnt++;
        total_cnt++;
        if ({addrb_o, out_data_o, out_addr_o} !== '0) begin
            $display("FAIL reset_data: addrb=%0d data=%0d addr=%0d want 0",
                     addrb_o, out_data_o, out_addr_o);
        end else pass_cnt++;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        total_cnt++;
        if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
            $display("FAIL reset_release_idle: busy=%b valid=%b want 0 0", busy_o, out_valid_o);
        end else pass_cnt++;
    endtask

    task automatic test_basic();
        run_pass(0, 4, 0, -1);
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (i >= rd_addr_q.size() || rd_addr_q[i] != i || rd_cyc_q[i] != 1 + i) begin
                $display("FAIL basic_addr%0d: got %0d want %0d on consecutive cycles", i,
                         (i < rd_addr_q.size()) ? rd_addr_q[i] : -1, i);
            end else pass_cnt++;
        end
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (i >= bd_q.size() || bd_q[i] !== mem_data(i) || ba_q[i] !== exp_oaddr(i) ||
                bl_q[i] !== (i == 3)) begin
                $display("FAIL basic_beat%0d: got data=%0h addr=%0d last=%0b want %0h %0d %0b",
                         i, (i < bd_q.size()) ? bd_q[i] : 8'h0, (i < ba_q.size()) ? ba_q[i] : 10'h0,
                         (i < bl_q.size()) ? bl_q[i] : 1'b0, mem_data(i), exp_oaddr(i), i == 3);
            end else pass_cnt++;
        end
        total_cnt++;
        // start accepted at the first edge; valid rises two edges later
        if (first_valid != 3 || bd_q.size() != 4) begin
            $display("FAIL basic_latency: first_valid=%0d beats=%0d want 3 4",
                     first_valid, bd_q.size());
        end else pass_cnt++;
        total_cnt++;
        if (bd_q.size() != 4 || beat_cyc_q[3] != beat_cyc_q[0] + 3 ||
            done_cyc != beat_cyc_q[3] + 1 || done_cnt != 1) begin
            $display("FAIL basic_done: done_cyc=%0d done_cnt=%0d want after last beat, 1",
                     done_cyc, done_cnt);
        end else pass_cnt++;
        total_cnt++;
        if (ea_err != 0) $display("FAIL basic_enb_a: got %0d errors want 0", ea_err);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        run_pass(200, 6, 1, -1);
        total_cnt++;
        if (bd_q.size() != 6) $display("FAIL bp_count: got %0d beats want 6", bd_q.size());
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            total_cnt++;
            if (i >= bd_q.size() || bd_q[i] !== mem_data(200 + i) ||
                ba_q[i] !== exp_oaddr(200 + i) || bl_q[i] !== (i == 5)) begin
                $display("FAIL bp_beat%0d: got data=%0h want %0h", i,
                         (i < bd_q.size()) ? bd_q[i] : 8'h0, mem_data(200 + i));
            end else pass_cnt++;
        end
        total_cnt++;
        if (stall_err != 0) $display("FAIL bp_stable: got %0d changes want 0", stall_err);
        else pass_cnt++;
        total_cnt++;
        if (max_ahead > 2) $display("FAIL bp_ahead: got %0d want <=2", max_ahead);
        else pass_cnt++;
        total_cnt++;
        if (done_cnt != 1) $display("FAIL bp_done: got %0d pulses want 1", done_cnt);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        int exp_a[3] = '{16383, 0, 1};
        run_pass(16383, 3, 0, -1);
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (i >= rd_addr_q.size() || rd_addr_q[i] != exp_a[i] || i >= bd_q.size() ||
                bd_q[i] !== mem_data(exp_a[i])) begin
                $display("FAIL wrap_addr%0d: got %0d want %0d", i,
                         (i < rd_addr_q.size()) ? rd_addr_q[i] : -1, exp_a[i]);
            end else pass_cnt++;
        end
    endtask

    task automatic test_zero();
        run_pass(77, 0, 0, -1);
        total_cnt++;
        if (first_enb >= 0 || first_valid >= 0) begin
            $display("FAIL zero_activity: enb_cyc=%0d valid_cyc=%0d want none",
                     first_enb, first_valid);
        end else pass_cnt++;
        total_cnt++;
        if (done_cyc != 1 || done_cnt != 1) begin
            $display("FAIL zero_done: done_cyc=%0d done_cnt=%0d want 1 1", done_cyc, done_cnt);
        end else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int beats = 0;
        int bad = 0;
        @(negedge clk);
        start_i = 1'b1; base_i = AW'(300); count_i = (AW+1)'(8); out_ready_i = 1'b1;
        for (int c = 0; c < 50 && beats < 2; c++) begin
            @(negedge clk);
            start_i = 1'b0;
            #1;
            if (out_valid_o && out_ready_i) beats++;
        end
        total_cnt++;
        if (beats != 2) $display("FAIL rstmid_beats: got %0d want 2", beats);
        else pass_cnt++;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({out_valid_o, out_last_o, enb_d_o, enb_a_o, busy_o, done_o} !== 6'b0 ||
            {addrb_o, out_data_o, out_addr_o} !== '0) begin
            $display("FAIL rstmid_outputs: valid=%b enb=%b busy=%b addrb=%0d data=%0h want 0",
                     out_valid_o, enb_d_o, busy_o, addrb_o, out_data_o);
        end else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (12) begin
            @(negedge clk);
            #1;
            if (out_valid_o || enb_d_o || done_o || busy_o) bad++;
        end
        total_cnt++;
        if (bad != 0) $display("FAIL rstmid_quiet: got %0d active cycles want 0", bad);
        else pass_cnt++;
        run_pass(5, 3, 0, -1);
        total_cnt++;
        if (bd_q.size() != 3 || bd_q[0] !== mem_data(5) || bd_q[2] !== mem_data(7)) begin
            $display("FAIL rstmid_restart: got %0d beats want 3 from addr 5", bd_q.size());
        end else pass_cnt++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            int base = $urandom_range(0, TOTAL - 1);
            int cnt  = $urandom_range(1, 12);
            int errs = 0;
            run_pass(base, cnt, 2, 2);
            if (bd_q.size() != cnt) errs++;
            for (int i = 0; i < cnt && i < bd_q.size(); i++) begin
                int a = (base + i) % TOTAL;
                if (bd_q[i] !== mem_data(a) || ba_q[i] !== exp_oaddr(a) ||
                    bl_q[i] !== (i == cnt - 1)) errs++;
            end
            total_cnt++;
            if (errs != 0 || stall_err != 0 || max_ahead > 2 || done_cnt != 1 || ea_err != 0) begin
                $display("FAIL rand%0d: base=%0d count=%0d beats=%0d errs=%0d stall=%0d ahead=%0d done=%0d want 0 errors",
                         n, base, cnt, bd_q.size(), errs, stall_err, max_ahead, done_cnt);
            end else pass_cnt++;
        end
    endtask

    initial begin
        rst = 1'b0; start_i = 1'b0; base_i = '0; count_i = '0; out_ready_i = 1'b0;
        dob_d_i = '0; dob_a_i = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/acpo_buff_reader.md
ACPO_BUFF_READER -- requirements
Module: acpo_buff_reader

Interface
REQ-001 SHALL have parameter SRAM_DEPTH, default 1024: data/address buffer depth per band.
REQ-002 SHALL have parameter BAND_WIDTH, default 16: number of bands; read address width AW = $clog2(SRAM_DEPTH)+$clog2(BAND_WIDTH) (14 at defaults).
REQ-003 SHALL have parameter DATA_WIDTH, default 8: data word width.
REQ-004 SHALL have parameter ADDRESS_WIDTH, default 10: width of stored address words.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port start_i, input, 1: one-cycle pulse that starts a read pass; accepted only in IDLE.
REQ-008 SHALL have port base_i, input, AW: first buffer address of the pass, sampled with start_i.
REQ-009 SHALL have port count_i, input, AW+1: number of entries to read, sampled with start_i.
REQ-010 SHALL have port enb_d_o, input-side read enable to the data buffer, output, 1.
REQ-011 SHALL have port enb_a_o, output, 1: read enable to the address buffer.
REQ-012 SHALL have port addrb_o, output, AW: read address shared by both buffers.
REQ-013 SHALL have port dob_d_i, input, DATA_WIDTH: data buffer read data, valid 1 cycle after enb_d_o.
REQ-014 SHALL have port dob_a_i, input, ADDRESS_WIDTH: address buffer read data, valid 1 cycle after enb_a_o.
REQ-015 SHALL have ports out_valid_o (output, 1), out_ready_i (input, 1): stream handshake; a beat transfers when both are 1.
REQ-016 SHALL have ports out_data_o (output, DATA_WIDTH), out_addr_o (output, ADDRESS_WIDTH), out_last_o (output, 1, marks final beat).
REQ-017 SHALL have ports busy_o (output, 1, high outside IDLE) and done_o (output, 1, one-cycle pulse at pass end).

Function
REQ-018 SHALL implement states IDLE, READ, DRAIN, DONE; IDLE->READ on start_i with count_i>0; IDLE->DONE on start_i with count_i==0.
REQ-019 SHALL in READ issue one read per cycle (enb_d_o=1, addrb_o=current pointer) only when FIFO occupancy plus in-flight reads < 2.
REQ-020 SHALL increment the read pointer by 1 per issued read, wrapping from SRAM_DEPTH*BAND_WIDTH-1 to 0.
REQ-021 SHALL move READ->DRAIN when the issued-read count reaches the sampled count.
REQ-022 SHALL capture returned words into a 2-entry FIFO one cycle after each issued read; the FIFO SHALL never overflow under any out_ready_i pattern.
REQ-023 SHALL drive out_valid_o from FIFO non-empty, out_data_o/out_addr_o from the FIFO head; out_data_o/out_addr_o SHALL hold stable while out_valid_o=1 and out_ready_i=0.
REQ-024 SHALL assert out_last_o only with the beat whose index equals count-1.
REQ-025 SHALL move DRAIN->DONE on the transfer of the last beat; DONE SHALL pulse done_o for exactly one cycle and return to IDLE.
REQ-026 SHALL ignore start_i outside IDLE.
REQ-027 SHALL sustain one beat per cycle when out_ready_i is held 1; first out_valid_o SHALL rise 2 cycles after start_i.

Reset
REQ-028 SHALL on rst=0 asynchronously enter IDLE, clear FIFO, pointer and counters; out_valid_o, out_last_o, enb_d_o, enb_a_o, busy_o, done_o = 0; addrb_o, out_data_o, out_addr_o = 0.
REQ-029 SHALL on reset mid-pass discard all in-flight and buffered data; no beat or done_o SHALL follow reset release without a new start_i.

Configuration
REQ-030 SHALL use macro ACPO_RD_ADDR_EN: when defined, enb_a_o mirrors enb_d_o and out_addr_o carries dob_a_i through the FIFO.
REQ-031 SHALL, without ACPO_RD_ADDR_EN, hold enb_a_o=0 and out_addr_o=0, omit address FIFO storage; data path behaviour unchanged.

Verification
REQ-032 SHALL test base=0, count=4, out_ready_i=1 -> addrb_o 0,1,2,3 on consecutive cycles; 4 beats, out_last_o on 4th, done_o one cycle after.
REQ-033 SHALL test count=6, out_ready_i toggling 1,0,1,0 -> 6 beats in order, no drop/duplicate, data stable while stalled, at most 2 reads ahead.
REQ-034 SHALL test base=16383, count=3 -> addrb_o 16383,0,1.
REQ-035 SHALL test start_i with count=0 -> no enb_d_o, no out_valid_o, done_o pulses 1 cycle later.
REQ-036 SHALL test rst=0 asserted after 2 of 8 beats -> outputs 0 immediately; after release no out_valid_o until next start_i.
REQ-037 SHALL test with ACPO_RD_ADDR_EN defined, dob_a_i=addr+100 -> out_addr_o equals 100+read address per beat; undefined -> enb_a_o and out_addr_o stay 0.
